// File: rtl/seg7_pkg.sv
// Shared code points, segment glyphs and scan FSM states for the 7-segment scan driver.
// Glyph bit order is seg[6]=a ... seg[0]=g, active-high.
package seg7_pkg;

   localparam logic [3:0] CODE_OFF      = 4'hF;
   localparam logic [3:0] CODE_DASH_MIN = 4'hA;

   localparam logic [6:0] GLYPH_0    = 7'b1111110;
   localparam logic [6:0] GLYPH_1    = 7'b0110000;
   localparam logic [6:0] GLYPH_2    = 7'b1101101;
   localparam logic [6:0] GLYPH_3    = 7'b1111001;
   localparam logic [6:0] GLYPH_4    = 7'b0110011;
   localparam logic [6:0] GLYPH_5    = 7'b1011011;
   localparam logic [6:0] GLYPH_6    = 7'b1011111;
   localparam logic [6:0] GLYPH_7    = 7'b1110010;
   localparam logic [6:0] GLYPH_8    = 7'b1111111;
   localparam logic [6:0] GLYPH_9    = 7'b1111011;
   localparam logic [6:0] GLYPH_DASH = 7'b0000001;
   localparam logic [6:0] GLYPH_OFF  = 7'b0000000;

   typedef enum logic {
      GAP  = 1'b0,
      SHOW = 1'b1
   } state_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit-code input bus and display pin bundle for seg7_scan_driver.
// master = datapath/board side, slave = the scan driver.
interface seg7_scan_driver_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] digits_in;
   logic [DIGITS-1:0]   dp_in;
   logic                load;
   logic                lzb_en;
   logic [6:0]          seg;
   logic                dp;
   logic [DIGITS-1:0]   dig_sel;
   logic                frame;

   modport master (
      output digits_in, dp_in, load, lzb_en,
      input  seg, dp, dig_sel, frame
   );

   modport slave (
      input  digits_in, dp_in, load, lzb_en,
      output seg, dp, dig_sel, frame
   );
endinterface

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to active-high 7-segment glyph.
// 10..14 render as a dash, 15 is blank.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   always_comb begin
      seg = GLYPH_OFF;
      if (code == CODE_OFF) begin
         seg = GLYPH_OFF;
      end else if (code >= CODE_DASH_MIN) begin
         seg = GLYPH_DASH;
      end else begin
         case (code)
            4'd0:    seg = GLYPH_0;
            4'd1:    seg = GLYPH_1;
            4'd2:    seg = GLYPH_2;
            4'd3:    seg = GLYPH_3;
            4'd4:    seg = GLYPH_4;
            4'd5:    seg = GLYPH_5;
            4'd6:    seg = GLYPH_6;
            4'd7:    seg = GLYPH_7;
            4'd8:    seg = GLYPH_8;
            4'd9:    seg = GLYPH_9;
            default: seg = GLYPH_OFF;
         endcase
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Double-buffered, time-multiplexed 7-segment scan driver with blank gaps and
// optional leading-zero blanking. All display outputs are registered.
//
// state | meaning
// GAP   | all digits dark for GAP_CYC cycles; idx advances on exit
// SHOW  | digit idx lit for SCAN_CYC cycles
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int SCAN_CYC    = 1000,
   parameter int GAP_CYC     = 8,
   parameter bit SEG_ACT_LOW = 1'b0,
   parameter bit DIG_ACT_LOW = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   seg7_scan_driver_if.slave  bus
);

   localparam int CNT_MAX = (SCAN_CYC > GAP_CYC) ? SCAN_CYC : GAP_CYC;
   localparam int CW      = $clog2(CNT_MAX);
   localparam int IW      = $clog2(DIGITS);
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYC - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                frame_start;

   logic [4*DIGITS-1:0] pend_dig_q, act_dig_q, act_dig_d;
   logic [DIGITS-1:0]   pend_dp_q, act_dp_q, act_dp_d;
   logic                lzb_q, lzb_d, lead;
   logic [DIGITS-1:0]   blank;
   logic [3:0]          code_sel;
   logic [6:0]          seg_dec, seg_hi;
   logic                dp_hi;
   logic [DIGITS-1:0]   dig_hi;

   logic [6:0]          seg_q;
   logic                dp_q, frame_q;
   logic [DIGITS-1:0]   dig_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= GAP;
         cnt_q   <= '0;
         idx_q   <= IDX_LAST;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      idx_d       = idx_q;
      frame_start = 1'b0;
      case (state_q)
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d     = SHOW;
               cnt_d       = '0;
               idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
               frame_start = (idx_q == IDX_LAST);
            end
         end
         SHOW: begin
            if (cnt_q == SCAN_LAST) begin
               state_d = GAP;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = GAP;
            cnt_d   = '0;
         end
      endcase
   end

   // Decode from the buffer contents that will be active after this edge, so
   // the first digit of a new frame already shows the freshly copied value.
   always_comb begin
      act_dig_d = frame_start ? pend_dig_q : act_dig_q;
      act_dp_d  = frame_start ? pend_dp_q  : act_dp_q;
      lzb_d     = frame_start ? bus.lzb_en : lzb_q;
   end

   always_comb begin
      blank = '0;
      lead  = lzb_d;
      for (int i = DIGITS - 1; i > 0; i--) begin
         if (lead && (act_dig_d[4*i +: 4] == 4'h0 || act_dig_d[4*i +: 4] == CODE_OFF))
            blank[i] = 1'b1;
         else
            lead = 1'b0;
      end
   end

   assign code_sel = blank[idx_d] ? CODE_OFF : act_dig_d[4*idx_d +: 4];

   seg7_decode u_decode (
      .code (code_sel),
      .seg  (seg_dec)
   );

   always_comb begin
      seg_hi = (state_d == SHOW) ? seg_dec : GLYPH_OFF;
      dp_hi  = (state_d == SHOW) && act_dp_d[idx_d];
      dig_hi = (state_d == SHOW) ? (DIGITS'(1) << idx_d) : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_dig_q <= {DIGITS{CODE_OFF}};
         pend_dp_q  <= '0;
         act_dig_q  <= {DIGITS{CODE_OFF}};
         act_dp_q   <= '0;
         lzb_q      <= 1'b0;
      end else begin
         if (bus.load) begin
            pend_dig_q <= bus.digits_in;
            pend_dp_q  <= bus.dp_in;
         end
         act_dig_q <= act_dig_d;
         act_dp_q  <= act_dp_d;
         lzb_q     <= lzb_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_q   <= {7{SEG_ACT_LOW}};
         dp_q    <= SEG_ACT_LOW;
         dig_q   <= {DIGITS{DIG_ACT_LOW}};
         frame_q <= 1'b0;
      end else begin
         seg_q   <= seg_hi ^ {7{SEG_ACT_LOW}};
         dp_q    <= dp_hi ^ SEG_ACT_LOW;
         dig_q   <= dig_hi ^ {DIGITS{DIG_ACT_LOW}};
         frame_q <= frame_start;
      end
   end

   assign bus.seg     = seg_q;
   assign bus.dp      = dp_q;
   assign bus.dig_sel = dig_q;
   assign bus.frame   = frame_q;

endmodule
